// File: rtl/cordic_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cordic_arbiter
// Purpose  : Shares one pipelined CORDIC sin/cos core between NUM_CH
//            requesters. A round-robin grant accepts at most one phase per
//            cycle and registers it onto the core's phase input. A tag shift
//            register, as deep as the core latency, remembers which channel
//            owns each slot so that the result can be steered back on a
//            shared response bus with a one-hot strobe. Per-channel credit
//            counters bound the work each requester may have in flight.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK_50M       in   1          system clock, rising edge
//   RST           in   1          synchronous active-high reset
//   req_valid     in   NUM_CH     per-channel request valid
//   req_phase     in   NUM_CH*18  channel i at [18i+17:18i]
//                                 [17:16] quadrant, [15:0] degrees 0..90
//   req_ready     out  NUM_CH     one-hot grant (all zero during reset)
//   cordic_phase  out  32         core phase input, {14'b0, phase18}
//   cordic_sin    in   32         core sine, signed Q16
//   cordic_cos    in   32         core cosine, signed Q16
//   rsp_valid     out  NUM_CH     one-hot result strobe, one cycle
//   rsp_sin       out  32         result sine (held between strobes)
//   rsp_cos       out  32         result cosine (held between strobes)
//   busy          out  1          work in flight or credits outstanding
// ============================================================================
module cordic_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int LATENCY = 18,
  parameter int CREDITS = 8
) (
  input  logic                   CLK_50M,
  input  logic                   RST,
  input  logic [NUM_CH-1:0]      req_valid,
  input  logic [NUM_CH*18-1:0]   req_phase,
  output logic [NUM_CH-1:0]      req_ready,
  output logic [31:0]            cordic_phase,
  input  logic [31:0]            cordic_sin,
  input  logic [31:0]            cordic_cos,
  output logic [NUM_CH-1:0]      rsp_valid,
  output logic [31:0]            rsp_sin,
  output logic [31:0]            rsp_cos,
  output logic                   busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int         c_ch_w    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int         c_ph_w    = 18;
  localparam logic [3:0] c_credits = 4'(CREDITS);

  // Channel index arithmetic modulo NUM_CH. NUM_CH need not be a power of
  // two, so the wrap is an explicit compare-and-subtract rather than a
  // truncation.
  function automatic logic [c_ch_w-1:0] f_wrap(input logic [c_ch_w-1:0] base,
                                               input int                off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return s[c_ch_w-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_ch_w-1:0] r_ptr;                       // round-robin search start
  logic [3:0]        r_outstanding [NUM_CH];      // credits in use per channel
  logic [LATENCY:0]  r_tag_vld;                   // slot occupied, per stage
  logic [c_ch_w-1:0] r_tag_ch      [0:LATENCY];   // slot owner, per stage
  logic [17:0]       r_phase;
  logic [NUM_CH-1:0] r_rsp_valid;
  logic [31:0]       r_rsp_sin;
  logic [31:0]       r_rsp_cos;

  // --------------------------------------------------------------------------
  // Combinational grant
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0] w_elig;
  logic              w_found;
  logic [c_ch_w-1:0] w_gidx;
  logic              w_xfer;
  logic [NUM_CH-1:0] w_grant;
  logic [17:0]       w_phase_sel;
  logic [NUM_CH-1:0] w_ret_onehot;
  logic [NUM_CH-1:0] w_dec;
  logic [NUM_CH-1:0] w_cnt_nz;

  // A channel may only be granted while it still holds a free credit.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_elig
    assign w_elig[i]   = req_valid[i] && (r_outstanding[i] < c_credits);
    assign w_cnt_nz[i] = (r_outstanding[i] != 4'd0);
  end

  // First eligible channel at or above r_ptr, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      if (!w_found && w_elig[f_wrap(r_ptr, off)]) begin
        w_found = 1'b1;
        w_gidx  = f_wrap(r_ptr, off);
      end
    end
  end

  // The grant is suppressed during reset so no request is acknowledged that
  // the reset would then throw away.
  assign w_xfer = w_found && !RST;

  always_comb begin
    w_grant = '0;
    if (w_xfer) w_grant[w_gidx] = 1'b1;
  end

  // Phase of the granted channel.
  always_comb begin
    w_phase_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_gidx == c_ch_w'(i)) w_phase_sel = req_phase[i*c_ph_w +: c_ph_w];
    end
  end

  // Owner of the result currently presented by the core.
  always_comb begin
    w_ret_onehot = '0;
    w_ret_onehot[r_tag_ch[LATENCY]] = 1'b1;
  end

  assign w_dec = r_tag_vld[LATENCY] ? w_ret_onehot : '0;

  // --------------------------------------------------------------------------
  // Issue stage: pointer, phase register and tag pipeline
  // --------------------------------------------------------------------------
  // tag[0] is loaded on the same edge as the phase register, so tag[k] sits
  // k cycles behind the phase the core saw; tag[LATENCY] therefore lines up
  // with the core outputs.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_ptr     <= '0;
      r_phase   <= '0;
      r_tag_vld <= '0;
      for (int k = 0; k <= LATENCY; k++) r_tag_ch[k] <= '0;
    end else begin
      r_tag_vld   <= {r_tag_vld[LATENCY-1:0], w_xfer};
      // Owner field of an empty slot is never looked at.
      r_tag_ch[0] <= w_gidx;
      for (int k = 1; k <= LATENCY; k++) r_tag_ch[k] <= r_tag_ch[k-1];
      // An idle slot drives a zero phase so the core input is deterministic.
      r_phase     <= w_xfer ? w_phase_sel : '0;
      if (w_xfer) r_ptr <= f_wrap(w_gidx, 1);
    end
  end

  // --------------------------------------------------------------------------
  // Credit counters
  // --------------------------------------------------------------------------
  // The decrement happens on the edge that raises rsp_valid, which frees the
  // credit in the same cycle the requester sees its result. A simultaneous
  // grant and return on one channel cancel out.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
    always_ff @(posedge CLK_50M) begin
      if (RST) begin
        r_outstanding[i] <= 4'd0;
      end else if (w_grant[i] && !w_dec[i]) begin
        r_outstanding[i] <= r_outstanding[i] + 4'd1;
      end else if (!w_grant[i] && w_dec[i] && (r_outstanding[i] != 4'd0)) begin
        r_outstanding[i] <= r_outstanding[i] - 4'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response register
  // --------------------------------------------------------------------------
  // Data holds its last value between strobes; only the strobe returns to 0.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_rsp_valid <= '0;
      r_rsp_sin   <= '0;
      r_rsp_cos   <= '0;
    end else if (r_tag_vld[LATENCY]) begin
      r_rsp_valid <= w_ret_onehot;
      r_rsp_sin   <= cordic_sin;
      r_rsp_cos   <= cordic_cos;
    end else begin
      r_rsp_valid <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req_ready    = w_grant;
  assign cordic_phase = {14'b0, r_phase};
  assign rsp_valid    = r_rsp_valid;
  assign rsp_sin      = r_rsp_sin;
  assign rsp_cos      = r_rsp_cos;
  // The response register counts as the final stage of the pipe, so busy
  // stays high through the cycle that presents the last result.
  assign busy         = (|r_tag_vld) || (|w_cnt_nz) || (|r_rsp_valid);

endmodule
`default_nettype wire

// File: tb/tb_cordic_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cordic_arbiter
// Purpose  : Scoreboard bench for cordic_arbiter. A behavioural core model
//            turns cordic_phase into ideal Q16 sin/cos after LATENCY cycles.
//            The stimulus process predicts grants from the arbitration rules
//            and pushes expected responses; a separate monitor pops them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_arbiter;

  localparam int NUM_CH  = 4;
  localparam int LATENCY = 18;
  localparam int CREDITS = 8;
  localparam int RSP_LAT = LATENCY + 2;

  logic                 CLK_50M = 1'b0;
  logic                 RST     = 1'b1;
  logic [NUM_CH-1:0]    req_valid = '0;
  logic [NUM_CH*18-1:0] req_phase = '0;
  logic [NUM_CH-1:0]    req_ready;
  logic [31:0]          cordic_phase;
  logic [31:0]          cordic_sin;
  logic [31:0]          cordic_cos;
  logic [NUM_CH-1:0]    rsp_valid;
  logic [31:0]          rsp_sin;
  logic [31:0]          rsp_cos;
  logic                 busy;

  cordic_arbiter #(.NUM_CH(NUM_CH), .LATENCY(LATENCY), .CREDITS(CREDITS)) dut (
    .CLK_50M     (CLK_50M),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_phase   (req_phase),
    .req_ready   (req_ready),
    .cordic_phase(cordic_phase),
    .cordic_sin  (cordic_sin),
    .cordic_cos  (cordic_cos),
    .rsp_valid   (rsp_valid),
    .rsp_sin     (rsp_sin),
    .rsp_cos     (rsp_cos),
    .busy        (busy)
  );

  always #5 CLK_50M = ~CLK_50M;

  longint cyc = 0;
  always @(posedge CLK_50M) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ideal Q16 sin/cos of quadrant*90 + degrees.
  function automatic int f_trig(input logic [17:0] p, input bit want_sin);
    int  q;
    int  a;
    real th;
    real x;
    q  = int'(p[17:16]);
    a  = int'(p[15:0]);
    th = (real'(q) * 90.0 + real'(a)) * 3.14159265358979 / 180.0;
    x  = (want_sin ? $sin(th) : $cos(th)) * 65536.0;
    return $rtoi((x >= 0.0) ? x + 0.5 : x - 0.5);
  endfunction

  // Behavioural core: fixed LATENCY-cycle pipe from phase to sin/cos.
  logic [17:0] core_pipe [LATENCY];
  always @(posedge CLK_50M) begin
    if (RST) begin
      for (int k = 0; k < LATENCY; k++) core_pipe[k] <= '0;
    end else begin
      core_pipe[0] <= cordic_phase[17:0];
      for (int k = 1; k < LATENCY; k++) core_pipe[k] <= core_pipe[k-1];
    end
  end
  always_comb begin
    cordic_sin = 32'(f_trig(core_pipe[LATENCY-1], 1'b1));
    cordic_cos = 32'(f_trig(core_pipe[LATENCY-1], 1'b0));
  end

  // Reference model state
  typedef struct {
    int     ch;
    int     s;
    int     c;
    longint due;
  } exp_t;

  exp_t        sb[$];              // expected responses in issue order
  longint      dq[NUM_CH][$];      // per-channel response cycles (credits)
  int          ptr       = 0;
  longint      last_t    = -1000;  // cycle of the latest transfer
  logic [17:0] exp_phase = '0;

  // One clock cycle: drive at posedge+1, predict and check at negedge.
  task automatic step(input logic rst_i, input logic [NUM_CH-1:0] v,
                      input logic [NUM_CH*18-1:0] ph);
    int                g;
    logic [NUM_CH-1:0] exp_rdy;
    bit                exp_busy;
    exp_t              e;
    @(posedge CLK_50M);
    #1;
    RST       = rst_i;
    req_valid = v;
    req_phase = ph;
    @(negedge CLK_50M);
    chk(cordic_phase == {14'b0, exp_phase}, "cordic_phase",
        longint'(cordic_phase), longint'({14'b0, exp_phase}));
    if (rst_i) begin
      chk(req_ready == '0, "ready_in_reset", longint'(req_ready), 0);
      sb.delete();
      for (int c = 0; c < NUM_CH; c++) dq[c].delete();
      ptr       = 0;
      last_t    = -1000;
      exp_phase = '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        while (dq[c].size() > 0 && dq[c][0] <= cyc) dq[c].delete(0);
      exp_busy = (last_t + RSP_LAT >= cyc);
      chk(busy == exp_busy, "busy", longint'(busy), longint'(exp_busy));
      g = -1;
      for (int off = 0; off < NUM_CH; off++) begin
        int c;
        c = (ptr + off) % NUM_CH;
        if (g < 0 && v[c] && dq[c].size() < CREDITS) g = c;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk(req_ready == exp_rdy, "req_ready", longint'(req_ready), longint'(exp_rdy));
      if (g >= 0) begin
        exp_phase = ph[18*g +: 18];
        e.ch  = g;
        e.s   = f_trig(exp_phase, 1'b1);
        e.c   = f_trig(exp_phase, 1'b0);
        e.due = cyc + RSP_LAT;
        sb.push_back(e);
        dq[g].push_back(cyc + RSP_LAT);
        ptr    = (g + 1) % NUM_CH;
        last_t = cyc;
      end else begin
        exp_phase = '0;
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever a result strobe appears.
  int last_s = 0;
  int last_c = 0;
  always @(negedge CLK_50M) begin
    exp_t              e;
    logic [NUM_CH-1:0] oh;
    if (RST) begin
      last_s = 0;
      last_c = 0;
    end else if (rsp_valid != '0) begin
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_rsp", longint'(rsp_valid), 0);
      end else begin
        e = sb.pop_front();
        oh = '0;
        oh[e.ch] = 1'b1;
        chk(rsp_valid == oh, "rsp_valid", longint'(rsp_valid), longint'(oh));
        chk(int'($signed(rsp_sin)) == e.s, "rsp_sin", longint'($signed(rsp_sin)), e.s);
        chk(int'($signed(rsp_cos)) == e.c, "rsp_cos", longint'($signed(rsp_cos)), e.c);
        chk(cyc == e.due, "rsp_cycle", cyc, e.due);
        last_s = e.s;
        last_c = e.c;
      end
    end else begin
      chk(int'($signed(rsp_sin)) == last_s && int'($signed(rsp_cos)) == last_c,
          "rsp_hold", longint'($signed(rsp_sin)), last_s);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk(1'b0, "missing_rsp", cyc, sb[0].due);
        sb.delete(0);
      end
    end
  end

  function automatic logic [17:0] rnd_ph();
    logic [1:0]  q;
    logic [15:0] a;
    q = 2'($urandom_range(0, 3));
    a = 16'($urandom_range(0, 90));
    return {q, a};
  endfunction

  function automatic logic [NUM_CH*18-1:0] rnd_vec();
    logic [NUM_CH*18-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[18*c +: 18] = rnd_ph();
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input int c);
    logic [NUM_CH-1:0] r;
    r = '0;
    r[c] = 1'b1;
    return r;
  endfunction

  function automatic bit near(input logic [31:0] v, input int target);
    int d;
    d = int'($signed(v)) - target;
    return (d >= -64) && (d <= 64);
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0);
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_CH*18-1:0] ph;
    int cnt;

    for (int k = 0; k < 3; k++) step(1'b1, '0, '0);
    chk(rsp_valid == '0, "reset_rsp_valid", longint'(rsp_valid), 0);
    chk(busy == 1'b0, "reset_busy", longint'(busy), 0);

    // Single request, ch0 at 30 degrees.
    ph = '0; ph[17:0] = 18'h0001E;
    step(1'b0, 4'b0001, ph);
    for (int k = 1; k <= 25; k++) begin
      step(1'b0, '0, '0);
      if (k == 20) begin
        chk(rsp_valid == 4'b0001, "single_valid", longint'(rsp_valid), 1);
        chk(near(rsp_sin, 32768), "single_sin", longint'($signed(rsp_sin)), 32768);
        chk(near(rsp_cos, 56756), "single_cos", longint'($signed(rsp_cos)), 56756);
      end
    end

    // Quadrant mapping on ch2.
    ph = '0; ph[36 +: 18] = {2'b01, 16'd30};
    step(1'b0, 4'b0100, ph);
    for (int k = 1; k <= 25; k++) begin
      step(1'b0, '0, '0);
      if (k == 20) begin
        chk(rsp_valid == 4'b0100, "q1_valid", longint'(rsp_valid), 4);
        chk(near(rsp_sin, 56756), "q1_sin", longint'($signed(rsp_sin)), 56756);
        chk(near(rsp_cos, -32768), "q1_cos", longint'($signed(rsp_cos)), -32768);
      end
    end
    ph = '0; ph[36 +: 18] = {2'b10, 16'd30};
    step(1'b0, 4'b0100, ph);
    for (int k = 1; k <= 25; k++) begin
      step(1'b0, '0, '0);
      if (k == 20) begin
        chk(near(rsp_sin, -32768), "q2_sin", longint'($signed(rsp_sin)), -32768);
        chk(near(rsp_cos, -56756), "q2_cos", longint'($signed(rsp_cos)), -56756);
      end
    end

    // Round robin with all channels requesting.
    step(1'b1, '0, '0);
    for (int k = 0; k <= 30; k++) begin
      if (k < 6) begin
        step(1'b0, 4'b1111, rnd_vec());
        chk(req_ready == onehot(k % 4), "rr_grant", longint'(req_ready), longint'(onehot(k % 4)));
      end else begin
        step(1'b0, '0, '0);
        if (k >= 20 && k <= 25)
          chk(rsp_valid == onehot((k - 20) % 4), "rr_rsp", longint'(rsp_valid),
              longint'(onehot((k - 20) % 4)));
      end
    end

    // Credit limit on ch1.
    step(1'b1, '0, '0);
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      step(1'b0, 4'b0010, rnd_vec());
      if (k >= 8 && k <= 19) chk(req_ready == '0, "credit_block", longint'(req_ready), 0);
      if (k == 20) chk(req_ready == 4'b0010, "credit_return", longint'(req_ready), 2);
      if (k >= 20 && k <= 39 && req_ready[1]) cnt++;
    end
    chk(cnt == 8, "credit_window", cnt, 8);
    idle(25);

    // Reset while results are in flight.
    step(1'b1, '0, '0);
    for (int k = 0; k < 5; k++) step(1'b0, 4'b1111, rnd_vec());
    idle(5);
    step(1'b1, '0, '0);
    step(1'b0, '0, '0);
    chk(busy == 1'b0, "post_reset_busy", longint'(busy), 0);
    idle(30);
    step(1'b0, 4'b0110, rnd_vec());
    chk(req_ready == 4'b0010, "post_reset_ptr", longint'(req_ready), 2);
    idle(25);

    // Idle gaps on ch3.
    cnt = 0;
    for (int k = 0; k <= 30; k++) begin
      if (k == 0 || k == 5) step(1'b0, 4'b1000, rnd_vec());
      else step(1'b0, '0, '0);
      if (rsp_valid[3]) cnt++;
    end
    chk(cnt == 2, "gap_pulses", cnt, 2);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      logic [NUM_CH-1:0] v;
      if ($urandom_range(0, 3) == 0) v = onehot(int'($urandom_range(0, NUM_CH - 1)));
      else v = NUM_CH'($urandom);
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, v, rnd_vec());
    end
    idle(30);
    chk(sb.size() == 0, "sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
